// File: rtl/qspi_flash_sequencer.sv
// Expands sector erase / page program / bulk erase requests into WREN, opcode+address+data
// and RDSR polling on the dword command interface; completion is reported by a done pulse.
// Requests are accepted only while idle with the downstream quiet; program data is pulled via wdata_valid/wdata_ready.
module qspi_flash_sequencer #(
  parameter int PAGE_DWORDS = 64,
  parameter int POLL_GAP    = 32,
  parameter int POLL_LIMIT  = 2000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic        req_quad,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        dif_wr,
  output logic [31:0] dif_data,
  input  logic        dif_busy,
  input  logic        dif_error,
  input  logic [7:0]  dif_readout
);

  localparam int PW  = $clog2(POLL_LIMIT + 1);
  localparam int GW  = $clog2(POLL_GAP + 1);
  localparam int DCW = $clog2(PAGE_DWORDS + 1);

  localparam logic [1:0] OP_SE  = 2'b00;
  localparam logic [1:0] OP_PP  = 2'b01;
  localparam logic [1:0] OP_BE  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_QPP  = 8'h32;
  localparam logic [7:0] CMD_BE   = 8'hC7;

  localparam logic [7:0] PROG_LEN = 8'(1 + PAGE_DWORDS);

  localparam logic [1:0] ERR_DIF     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_HDR,
    S_WREN_WAIT,
    S_OP_HDR,
    S_OP_ADDR,
    S_OP_DATA,
    S_OP_WAIT,
    S_POLL_GAP,
    S_RDSR_HDR,
    S_RDSR_WAIT,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t          state;
  logic [1:0]      op_r;
  logic [23:0]     addr_r;
  logic            quad_r;
  logic [PW-1:0]   poll_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [DCW-1:0]  data_cnt;
  logic            seen_busy;
  logic [31:0]     op_hdr;
  logic            unused_readout;

  // Only the WIP bit of the status byte matters here.
  assign unused_readout = ^dif_readout[7:1];

  function automatic logic [31:0] make_hdr(input logic [7:0] cmd, input logic [7:0] len,
                                           input logic quad);
    return {15'b0, quad, len, cmd};
  endfunction

  // Accept only when idle and the downstream is neither busy nor being strobed.
  assign req_ready = (state == S_IDLE) && !dif_busy && !dif_wr;

  // Operation header chosen from the latched request.
  always_comb begin
    op_hdr = make_hdr(CMD_SE, 8'd1, 1'b0);
    case (op_r)
      OP_PP:   op_hdr = quad_r ? make_hdr(CMD_QPP, PROG_LEN, 1'b1)
                               : make_hdr(CMD_PP, PROG_LEN, 1'b0);
      OP_BE:   op_hdr = make_hdr(CMD_BE, 8'd0, 1'b0);
      default: op_hdr = make_hdr(CMD_SE, 8'd1, 1'b0);
    endcase
  end

  // Main sequencer: all outputs registered; a strobe is raised on entry to each *_HDR/ADDR state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      dif_wr      <= 1'b0;
      dif_data    <= '0;
      wdata_ready <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      op_r        <= '0;
      addr_r      <= '0;
      quad_r      <= 1'b0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      data_cnt    <= '0;
      seen_busy   <= 1'b0;
    end else begin
      dif_wr <= 1'b0;
      done   <= 1'b0;
      // Busy is reported a cycle late; completion is only trusted after it has been seen high.
      if (dif_busy) seen_busy <= 1'b1;

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_r     <= req_op;
            addr_r   <= req_addr;
            quad_r   <= req_quad && (req_op == OP_PP);
            err      <= 1'b0;
            err_code <= '0;
            if (req_op == OP_ILL) begin
              state    <= S_FAIL;
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
              done     <= 1'b1;
            end else begin
              state     <= S_WREN_HDR;
              dif_wr    <= 1'b1;
              dif_data  <= make_hdr(CMD_WREN, 8'd0, 1'b0);
              seen_busy <= 1'b0;
            end
          end
        end

        S_WREN_HDR: state <= S_WREN_WAIT;

        S_WREN_WAIT: begin
          if (dif_error) begin
            state    <= S_FAIL;
            err      <= 1'b1;
            err_code <= ERR_DIF;
            done     <= 1'b1;
          end else if (seen_busy && !dif_busy) begin
            state     <= S_OP_HDR;
            dif_wr    <= 1'b1;
            dif_data  <= op_hdr;
            poll_cnt  <= '0;
            seen_busy <= 1'b0;
          end
        end

        S_OP_HDR: begin
          if (op_r == OP_BE) begin
            state <= S_OP_WAIT;
          end else begin
            state    <= S_OP_ADDR;
            dif_wr   <= 1'b1;
            dif_data <= {8'h00, addr_r};
          end
        end

        S_OP_ADDR: begin
          if (op_r == OP_PP) begin
            state       <= S_OP_DATA;
            wdata_ready <= 1'b1;
            data_cnt    <= '0;
          end else begin
            state <= S_OP_WAIT;
          end
        end

        // Every accepted data dword is forwarded as one strobe; gaps simply produce no strobe.
        S_OP_DATA: begin
          if (dif_error) begin
            state       <= S_FAIL;
            wdata_ready <= 1'b0;
            err         <= 1'b1;
            err_code    <= ERR_DIF;
            done        <= 1'b1;
          end else if (wdata_valid) begin
            dif_wr   <= 1'b1;
            dif_data <= wdata;
            if (data_cnt == DCW'(PAGE_DWORDS - 1)) begin
              state       <= S_OP_WAIT;
              wdata_ready <= 1'b0;
            end else begin
              data_cnt <= data_cnt + 1'b1;
            end
          end
        end

        S_OP_WAIT: begin
          if (dif_error) begin
            state    <= S_FAIL;
            err      <= 1'b1;
            err_code <= ERR_DIF;
            done     <= 1'b1;
          end else if (seen_busy && !dif_busy) begin
            state   <= S_POLL_GAP;
            gap_cnt <= '0;
          end
        end

        S_POLL_GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            state     <= S_RDSR_HDR;
            dif_wr    <= 1'b1;
            dif_data  <= make_hdr(CMD_RDSR, 8'd0, 1'b0);
            seen_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_RDSR_HDR: state <= S_RDSR_WAIT;

        S_RDSR_WAIT: begin
          if (dif_error) begin
            state    <= S_FAIL;
            err      <= 1'b1;
            err_code <= ERR_DIF;
            done     <= 1'b1;
          end else if (seen_busy && !dif_busy) begin
            state <= S_CHECK;
          end
        end

        // WIP clear finishes the operation; otherwise poll again until the limit is hit.
        S_CHECK: begin
          if (!dif_readout[0]) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (poll_cnt == PW'(POLL_LIMIT)) begin
            state    <= S_FAIL;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            done     <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            gap_cnt  <= '0;
            state    <= S_POLL_GAP;
          end
        end

        S_DONE:  state <= S_IDLE;
        S_FAIL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Scoreboard bench for qspi_flash_sequencer with a behavioural dword-interface model.
// Stimulus pushes expected strobes and completion status; a negedge monitor pops and compares.
// The downstream model holds busy after reset and for a few cycles after each transfer.
module tb_qspi_flash_sequencer;
  localparam int PAGE_DWORDS = 64;
  localparam int POLL_GAP    = 4;
  localparam int POLL_LIMIT  = 4;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [23:0] req_addr = '0;
  logic        req_quad = 1'b0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        dif_wr;
  logic [31:0] dif_data;
  logic        dif_busy;
  logic        dif_error;
  logic [7:0]  dif_readout;

  qspi_flash_sequencer #(
    .PAGE_DWORDS(PAGE_DWORDS),
    .POLL_GAP(POLL_GAP),
    .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_quad(req_quad),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .done(done), .err(err), .err_code(err_code),
    .dif_wr(dif_wr), .dif_data(dif_data), .dif_busy(dif_busy),
    .dif_error(dif_error), .dif_readout(dif_readout)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  done_q[$];
  logic [7:0]  rd_q[$];
  logic        rd_default = 1'b0;
  logic        err_inject = 1'b0;
  int          hs_cnt = 0;
  int          strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Downstream dword-interface model
  int         boot;
  logic       active;
  logic [7:0] rem;
  int         tail;
  logic [7:0] cur_cmd;
  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      dif_busy <= 1'b1; dif_error <= 1'b0; dif_readout <= '0;
      boot <= 6; active <= 1'b0; rem <= '0; tail <= 0; cur_cmd <= '0;
    end else begin
      dif_error <= 1'b0;
      if (boot != 0) begin
        boot <= boot - 1;
        if (boot == 1) dif_busy <= 1'b0;
      end else if (!active) begin
        if (dif_wr) begin
          cur_cmd <= dif_data[7:0]; rem <= dif_data[15:8];
          tail <= 3; active <= 1'b1; dif_busy <= 1'b1;
        end
      end else if (rem != 0) begin
        if (dif_wr) rem <= rem - 8'd1;
      end else if (tail != 0) begin
        tail <= tail - 1;
      end else begin
        active <= 1'b0; dif_busy <= 1'b0;
        if (cur_cmd == 8'h05) begin
          if (rd_q.size() > 0) dif_readout <= rd_q.pop_front();
          else dif_readout <= {7'b0, rd_default};
        end
        if (err_inject && cur_cmd != 8'h05 && cur_cmd != 8'h06) dif_error <= 1'b1;
      end
    end
  end

  // Monitor: compare every strobe and every done pulse against the scoreboard
  always @(negedge clk_in) begin
    if (!reset) begin
      if (wdata_valid && wdata_ready) hs_cnt++;
      if (dif_wr) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: got 0x%08h expected no strobe", dif_data);
        end else begin
          check("dif_data", dif_data, exp_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          check("done_status", {29'b0, err, err_code}, {29'b0, done_q.pop_front()});
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic quad);
    int t = 0;
    @(negedge clk_in);
    while (!req_ready && t < 200) begin @(negedge clk_in); t++; end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_quad = quad;
    @(posedge clk_in); #1;
    req_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] base, input bit gappy);
    int i = 0;
    int t = 0;
    bit ph = 1'b0;
    bit hs;
    wdata = base; wdata_valid = 1'b1;
    while (i < n && t < 5000) begin
      @(negedge clk_in); hs = wdata_valid && wdata_ready;
      @(posedge clk_in); #1; t++;
      if (hs) i++;
      ph = ~ph;
      wdata = base + 32'(i);
      wdata_valid = (i < n) && (!gappy || ph);
    end
    wdata_valid = 1'b0;
    check("feed_count", 32'(i), 32'(n));
  endtask

  task automatic wait_idle(input string name, input int maxcyc);
    int t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && t < maxcyc) begin
      @(negedge clk_in); t++;
    end
    check({name, "_pending"}, 32'(exp_q.size() + done_q.size()), 32'd0);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic wait_not_busy();
    int t = 0;
    while (dif_busy && t < 100) begin @(negedge clk_in); t++; end
    check("busy_release", {31'b0, dif_busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hs0, s0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_dif_wr", {31'b0, dif_wr}, 32'd0);
    check("rst_dif_data", dif_data, 32'd0);
    check("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_err_code", {30'b0, err_code}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk_in); reset = 1'b0;
    @(negedge clk_in);
    check("ready_while_busy", {31'b0, req_ready}, 32'd0);
    wait_not_busy();
    @(negedge clk_in);
    check("ready_idle", {31'b0, req_ready}, 32'd1);

    // Bulk erase with WIP stuck: 5 polls then timeout
    rd_default = 1'b1;
    exp_q.push_back(32'h00000006); exp_q.push_back(32'h000000C7);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h00000005);
    done_q.push_back(3'b110);
    issue(2'b10, 24'h000000, 1'b0);
    wait_idle("bulk", 2000);
    check("bulk_err_sticky", {31'b0, err}, 32'd1);
    check("bulk_err_code", {30'b0, err_code}, 32'd2);
    rd_default = 1'b0;

    // Sector erase, WIP busy twice then clear
    rd_q.push_back(8'h03); rd_q.push_back(8'h03); rd_q.push_back(8'h00);
    exp_q.push_back(32'h00000006); exp_q.push_back(32'h000001D8); exp_q.push_back(32'h00012345);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h00000005);
    done_q.push_back(3'b000);
    issue(2'b00, 24'h012345, 1'b0);
    @(negedge clk_in);
    check("err_cleared", {31'b0, err}, 32'd0);
    check("err_code_cleared", {30'b0, err_code}, 32'd0);
    wait_idle("sector", 2000);

    // Quad page program with gappy data
    rd_q.push_back(8'h00);
    exp_q.push_back(32'h00000006); exp_q.push_back(32'h00014132); exp_q.push_back(32'h00000100);
    for (int i = 0; i < PAGE_DWORDS; i++) exp_q.push_back(32'hA5000000 + 32'(i));
    exp_q.push_back(32'h00000005);
    done_q.push_back(3'b000);
    hs0 = hs_cnt;
    issue(2'b01, 24'h000100, 1'b1);
    feed(PAGE_DWORDS, 32'hA5000000, 1'b1);
    wait_idle("program", 3000);
    check("program_handshakes", 32'(hs_cnt - hs0), 32'(PAGE_DWORDS));

    // Illegal op: no traffic
    s0 = strobe_cnt;
    done_q.push_back(3'b111);
    issue(2'b11, 24'h000055, 1'b0);
    wait_idle("illegal", 100);
    check("illegal_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Downstream error during OP_WAIT: no RDSR
    err_inject = 1'b1;
    s0 = strobe_cnt;
    exp_q.push_back(32'h00000006); exp_q.push_back(32'h000001D8); exp_q.push_back(32'h00000ABC);
    done_q.push_back(3'b101);
    issue(2'b00, 24'h000ABC, 1'b0);
    wait_idle("dif_error", 2000);
    err_inject = 1'b0;
    check("dif_error_strobes", 32'(strobe_cnt - s0), 32'd3);

    // Reset during OP_DATA
    exp_q.push_back(32'h00000006); exp_q.push_back(32'h00004102); exp_q.push_back(32'h00000200);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'hB0000000 + 32'(i));
    issue(2'b01, 24'h000200, 1'b0);
    feed(5, 32'hB0000000, 1'b0);
    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 50) begin @(negedge clk_in); t++; end
    end
    check("pre_reset_pending", 32'(exp_q.size()), 32'd0);
    check("pre_reset_wdata_ready", {31'b0, wdata_ready}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_dif_wr", {31'b0, dif_wr}, 32'd0);
    check("mid_rst_dif_data", dif_data, 32'd0);
    check("mid_rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    s0 = strobe_cnt;
    @(negedge clk_in);
    check("post_rst_ready_busy", {31'b0, req_ready}, 32'd0);
    wait_not_busy();
    @(negedge clk_in);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_strobes", 32'(strobe_cnt - s0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/qspi_flash_sequencer.md
Name: qspi_flash_sequencer

Overview:
- Sequences complete flash operations (sector erase, page program, bulk erase) on top of the dword command interface.
- Each request expands into WREN, then the operation command with address and data dwords, then RDSR polling until WIP clears.
- Runs on the same clk_in domain as the dword command interface. Hides the header/length/quad dword protocol and the downstream busy handshake from the host-side logic.

Parameters:
- PAGE_DWORDS, 64: data dwords per page program (256 bytes).
- POLL_GAP, 32: idle clk_in cycles between consecutive RDSR polls.
- POLL_LIMIT, 2000000: maximum RDSR polls before timeout; counter width is $clog2(POLL_LIMIT+1).

Ports:
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_op  in  2  00 sector erase, 01 page program, 10 bulk erase, 11 illegal.
- req_addr  in  24  flash byte address.
- req_quad  in  1  use quad page program (0x32) when op=01.
- wdata_valid  in  1  program data dword available.
- wdata_ready  out  1  program data dword consumed this cycle.
- wdata  in  32  program data.
- done  out  1  one-cycle pulse, operation finished (success or error).
- err  out  1  sticky error flag, cleared on next accepted request.
- err_code  out  2  01 downstream error, 10 poll timeout, 11 illegal op.
- dif_wr  out  1  write strobe to dword interface.
- dif_data  out  32  header/data dword to dword interface.
- dif_busy  in  1  dword interface busy.
- dif_error  in  1  controller error from dword interface.
- dif_readout  in  8  last byte read by the controller.

Behaviour:
- Reset (async): state=IDLE. dif_wr=0, dif_data=0, wdata_ready=0, done=0, err=0, err_code=0, counters=0.
- Header dword format: {15'b0, quad, len[7:0], cmd[7:0]}. len counts the data dwords that follow.
- Address dword format: {8'h00, addr[23:0]}.
- req_ready = (state==IDLE) && !dif_busy && !dif_wr. dif_busy is 1 after downstream reset, so no request is accepted until it drops.
- Request capture: on acceptance, latch op/addr/quad and clear err/err_code. If op=11, go to FAIL with code 11; no flash traffic is issued.
- Every header is issued as a single-cycle dif_wr pulse. The following state must see dif_busy=1 before it may evaluate completion: dif_busy is registered one cycle late, and a stale 0 must not be taken as done.
- WREN_HDR: header cmd=0x06, len=0. Then WREN_WAIT until dif_busy=0.
- OP_HDR, by op:
  - sector erase: cmd=0xD8, len=1, quad=0.
  - page program: cmd=0x02 (quad=0), or cmd=0x32 with quad=1 when req_quad; len=1+PAGE_DWORDS.
  - bulk erase: cmd=0xC7, len=0.
- OP_ADDR: address dword with dif_wr=1 for one cycle, next cycle after the header. Skipped for bulk erase.
- OP_DATA (program only): wdata_ready=1 while in state. dif_wr=wdata_valid, dif_data=wdata.
  - Gaps are allowed; downstream only counts strobed cycles.
  - Leave after PAGE_DWORDS strobed dwords; exactly PAGE_DWORDS handshakes occur.
- OP_WAIT: until dif_busy=0.
- POLL_GAP: count POLL_GAP cycles.
- RDSR_HDR: header cmd=0x05, len=0. Then RDSR_WAIT until dif_busy=0.
- CHECK:
  - dif_readout[0]=0: go to DONE.
  - else if poll count = POLL_LIMIT: go to FAIL with code 10.
  - else increment poll count and go to POLL_GAP.
- Poll count resets to 0 at each OP_HDR.
- dif_error: if it goes high in any wait state, go to FAIL with code 01. It takes priority over busy falling in the same cycle.
- DONE: done=1 for one cycle, then IDLE.
- FAIL: err=1, err_code set, done=1 for one cycle, then IDLE.
- Simultaneous req_valid in the cycle after done: not accepted until IDLE is re-entered and req_ready is evaluated (minimum 1 idle cycle).
- Reset mid-operation: immediate return to IDLE. The partial downstream transfer is abandoned; the downstream is reset by the same signal.
- Total dif_wr strobes per operation:
  - program: 1+1+1+PAGE_DWORDS+N_polls.
  - sector erase: 3+N_polls.
  - bulk erase: 2+N_polls.

Test Plan:
- Sector erase at 0x012345; downstream model reports readout=0x03 twice, then 0x00 -> dif_data sequence is 0x00000006, 0x000001D8, 0x00012345, then three polls of 0x00000005; done pulses once; err=0.
- Quad page program at 0x000100 with PAGE_DWORDS=64; wdata_valid toggled 1/0 -> header 0x00014132, address 0x00000100, then 64 strobed data dwords in order with no duplicates; wdata_ready handshakes=64.
- Bulk erase with WIP stuck at 1, POLL_LIMIT=4 -> exactly 5 RDSR headers; done pulses; err=1, err_code=10. Next accepted request clears err.
- req_op=11 -> no dif_wr strobes; done pulses; err_code=11.
- dif_error asserted during OP_WAIT -> FAIL with err_code=01, no RDSR issued.
- Reset asserted during OP_DATA -> outputs zero within the reset cycle; req_ready stays 0 until dif_busy=0.
